// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU issue path.
// Op encodings, FSM states and per-op latency lookup.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned op_lat(
    input logic [1:0]  op,
    input int unsigned addsub_lat,
    input int unsigned mul_lat,
    input int unsigned div_lat
  );
    int unsigned lat;
    lat = addsub_lat;
    unique case (1'b1)
      (op == OP_MUL): lat = mul_lat;
      (op == OP_DIV): lat = div_lat;
      default:        lat = addsub_lat;
    endcase
    return lat;
  endfunction

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fpu_issue_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Grant is one-hot or zero; history advances only on update.
import fpu_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

  // Reset to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one FP ALU between two requesters.
// Issues an op, waits its fixed latency, returns the result.
import fpu_pkg::*;

module fpu_issue_arbiter #(
  parameter int unsigned ADDSUB_LAT = 1,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned DIV_LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req0_select,
  input  logic [1:0]  req1_select,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_select,
  input  logic [31:0] alu_out,
  input  logic        alu_exception,
  input  logic        alu_zerodiv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_exception,
  output logic        rsp_zerodiv,
  output logic [7:0]  exc_count
);

  localparam int unsigned MAXLAT =
    max3(ADDSUB_LAT, MUL_LAT, DIV_LAT);
  localparam int CW = $clog2(MAXLAT + 1);

  state_t        state;
  state_t        state_n;
  logic [1:0]    grant;
  logic          take;
  logic          gid;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [1:0]    op_sel;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_m1;
  logic          rsp_hs;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (take),
    .grant  (grant)
  );

  assign req_ready = (state == IDLE) ? (req_valid & grant) : 2'b00;
  assign take      = |req_ready;
  assign gid       = grant[1];
  assign op_a      = gid ? req1_a : req0_a;
  assign op_b      = gid ? req1_b : req0_b;
  assign op_sel    = gid ? req1_select : req0_select;
  assign lat_m1    =
    CW'(op_lat(op_sel, ADDSUB_LAT, MUL_LAT, DIV_LAT) - 1);
  assign rsp_hs    = (state == DONE) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (take)       state_n = BUSY;
      BUSY:    if (cnt == '0)  state_n = DONE;
      DONE:    if (rsp_ready)  state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_select    <= OP_ADD;
      rsp_id        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_exception <= 1'b0;
      rsp_zerodiv   <= 1'b0;
      exc_count     <= '0;
      cnt           <= '0;
    end else begin
      if (take) begin
        alu_a      <= op_a;
        alu_b      <= op_b;
        alu_select <= op_sel;
        rsp_id     <= gid;
        cnt        <= lat_m1;
      end
      if (state == BUSY) begin
        if (cnt == '0) begin
          rsp_data      <= alu_out;
          rsp_exception <= alu_exception;
          rsp_zerodiv   <= alu_zerodiv;
          rsp_valid     <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        // Count flagged responses only once the consumer takes them.
        if ((rsp_exception | rsp_zerodiv) && exc_count != 8'hFF)
          exc_count <= exc_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter.
// Behavioural ALU stand-in plus a transaction-level model.
module tb_fpu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_select, req1_select;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_select;
  logic [31:0] alu_out;
  logic        alu_exception, alu_zerodiv;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_exception, rsp_zerodiv;
  logic [7:0]  exc_count;

  int pass_n = 0;
  int fail_n = 0;
  int total_n = 0;
  int age = 1000;
  bit last;
  int exc_m;

  always #5 clk = ~clk;

  fpu_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_select(req0_select), .req1_select(req1_select),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_exception(alu_exception),
    .alu_zerodiv(alu_zerodiv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_exception(rsp_exception), .rsp_zerodiv(rsp_zerodiv),
    .exc_count(exc_count)
  );

  function automatic int lat_of(input logic [1:0] s);
    if (s == 2'b10) return 2;
    if (s == 2'b11) return 4;
    return 1;
  endfunction

  // {exception, zerodiv, result}
  function automatic logic [33:0] falu(
    input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    if (s == 2'b00 && a == 32'h3F800000 && b == 32'h40000000)
      return {2'b00, 32'h40400000};
    if (s == 2'b10 && a == 32'h3F800000 && b == 32'hC0000000)
      return {2'b00, 32'hC0000000};
    if (s == 2'b11 && b == 32'h0)
      return {2'b01, 32'h7F800000};
    if (a == 32'h7F800000 && b == 32'h7F800000)
      return {2'b10, 32'h7F800000};
    return {a[0] & b[0], 1'b0, a ^ {b[15:0], b[31:16]} ^ {30'd0, s}};
  endfunction

  // Stand-in ALU: garbage until the op latency has elapsed.
  always @(posedge clk) begin
    if (|(req_valid & req_ready)) age <= 0;
    else if (age < 1000) age <= age + 1;
  end

  always_comb begin
    {alu_exception, alu_zerodiv, alu_out} = {2'b11, 32'hDEADBEEF};
    if (age + 1 >= lat_of(alu_select))
      {alu_exception, alu_zerodiv, alu_out} =
        falu(alu_a, alu_b, alu_select);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] mask,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input int hold);
    int g, lat;
    logic [33:0] e;
    logic [31:0] a, b;
    logic [1:0] s;
    req_valid = mask;
    req0_a = a0; req0_b = b0; req0_select = s0;
    req1_a = a1; req1_b = b1; req1_select = s1;
    rsp_ready = (hold == 0);
    #1;
    g = (mask == 2'b11) ? (last ? 0 : 1) : (mask[1] ? 1 : 0);
    chk("req_ready", {30'd0, req_ready}, 32'd1 << g);
    last = g[0];
    a = g ? a1 : a0;
    b = g ? b1 : b0;
    s = g ? s1 : s0;
    lat = lat_of(s);
    e = falu(a, b, s);
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < lat; j++) begin
      chk("busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("busy_req_ready", {30'd0, req_ready}, 32'd0);
      chk("alu_a", alu_a, a);
      chk("alu_b", alu_b, b);
      chk("alu_select", {30'd0, alu_select}, {30'd0, s});
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data", rsp_data, e[31:0]);
      chk("rsp_id", {31'd0, rsp_id}, g);
      chk("rsp_flags", {30'd0, rsp_exception, rsp_zerodiv},
          {30'd0, e[33:32]});
      chk("exc_hold", {24'd0, exc_count}, exc_m);
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if ((e[33] | e[32]) && exc_m < 255) exc_m++;
    chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    chk("exc_count", {24'd0, exc_count}, exc_m);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_select = 2'b00; req1_select = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_exc", {24'd0, exc_count}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst = 1'b0;
    last = 1'b1;
    exc_m = 0;

    issue(2'b01, 32'h3F800000, 32'h40000000, 0, 0, 2'b00, 2'b00, 0);
    issue(2'b10, 0, 0, 32'h3F800000, 32'hC0000000, 2'b00, 2'b10, 0);
    for (int i = 0; i < 8; i++)
      issue(2'b11, $urandom, $urandom, $urandom, $urandom,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0);
    issue(2'b01, 32'h3F800000, 32'h0, 0, 0, 2'b11, 2'b00, 10);
    for (int i = 0; i < 40; i++)
      issue(2'($urandom_range(1, 3)), $urandom, $urandom,
            $urandom, $urandom,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3));

    // Reset in the middle of a divide.
    issue(2'b01, 32'h3F800000, 32'h0, 0, 0, 2'b11, 2'b00, 0);
    req_valid = 2'b01;
    req0_select = 2'b11;
    req0_b = 32'h40000000;
    #1;
    chk("pre_rst_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_alu_sel", {30'd0, alu_select}, 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_exc", {24'd0, exc_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last = 1'b1;
    exc_m = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
    end
    issue(2'b11, 32'h3F800000, 32'h40000000,
          32'h3F800000, 32'hC0000000, 2'b00, 2'b10, 0);

    for (int i = 0; i < 260; i++)
      issue(2'b01, 32'h7F800000, 32'h7F800000, 0, 0, 2'b00, 2'b00, 0);
    chk("exc_saturated", {24'd0, exc_count}, 32'd255);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
